// File: rtl/pin_debouncer.sv
// Reads one mechanical button or switch on a board pin. The raw level passes through a
// two-flop synchroniser, is debounced by a small FSM, and drives level, strobe and counter outputs.
module pin_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 16000,
  parameter int LONG_PRESS_CYCLES = 8000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin_in,
  output logic       level,
  output logic       press,
  // 'release' is a reserved word in SystemVerilog, so the release strobe takes this name
  output logic       release_strobe,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int CNT_W  = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = ($clog2(LONG_PRESS_CYCLES) < 1) ? 1 : $clog2(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic              IDLE_PIN  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } state_t;

  state_t            state_reg;
  logic              sync1_reg;
  logic              sync2_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              done_reg;
  logic              s;

  // s = 1 always means "pressed", whatever the pin polarity
  assign s = sync2_reg ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= IDLE_PIN;
      sync2_reg <= IDLE_PIN;
    end else begin
      sync1_reg <= pin_in;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RELEASED;
      cnt_reg        <= '0;
      hold_reg       <= '0;
      done_reg       <= 1'b0;
      level          <= 1'b0;
      press          <= 1'b0;
      release_strobe <= 1'b0;
      long_press     <= 1'b0;
      press_count    <= 8'd0;
    end else begin
      press          <= 1'b0;
      release_strobe <= 1'b0;
      long_press     <= 1'b0;

      // Hold timing runs through release bounces; the threshold compares the pre-increment value
      if (state_reg == PRESSED || state_reg == CONFIRM_RELEASE) begin
        if (hold_reg != HOLD_MAX) hold_reg <= hold_reg + 1'b1;
        if (hold_reg == HOLD_LAST && !done_reg) begin
          long_press <= 1'b1;
          done_reg   <= 1'b1;
        end
      end

      case (state_reg)
        RELEASED: begin
          if (s) begin
            state_reg <= CONFIRM_PRESS;
            cnt_reg   <= CNT_W'(1);
          end
        end
        CONFIRM_PRESS: begin
          if (!s) begin
            state_reg <= RELEASED;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= PRESSED;
            level       <= 1'b1;
            press       <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_reg    <= '0;
            done_reg    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_reg <= CONFIRM_RELEASE;
            cnt_reg   <= CNT_W'(1);
          end
        end
        CONFIRM_RELEASE: begin
          if (s) begin
            state_reg <= PRESSED;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg      <= RELEASED;
            level          <= 1'b0;
            release_strobe <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_debouncer.sv
// Directed bench for pin_debouncer: an active-low and an active-high instance receive
// mirrored pins, so every step checks both polarities with identical expected timing.
module tb_pin_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pin_a = 1'b1;
  logic       pin_b;
  logic       level_a, press_a, rel_a, long_a;
  logic       level_b, press_b, rel_b, long_b;
  logic [7:0] count_a, count_b;

  int checks = 0;
  int errors = 0;
  int press_n_a = 0, rel_n_a = 0, long_n_a = 0;
  int press_n_b = 0, rel_n_b = 0, long_n_b = 0;
  int base_press, base_rel;

  assign pin_b = ~pin_a;

  always #5 clk = ~clk;

  pin_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .pin_in(pin_a), .level(level_a), .press(press_a),
    .release_strobe(rel_a), .long_press(long_a), .press_count(count_a)
  );

  pin_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .pin_in(pin_b), .level(level_b), .press(press_b),
    .release_strobe(rel_b), .long_press(long_b), .press_count(count_b)
  );

  // Tally strobe pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (press_a) press_n_a++;
    if (rel_a)   rel_n_a++;
    if (long_a)  long_n_a++;
    if (press_b) press_n_b++;
    if (rel_b)   rel_n_b++;
    if (long_b)  long_n_b++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int lvl, input int prs, input int rel,
                         input int lng, input int cnt);
    chk({tag, " level_a"}, int'(level_a), lvl);
    chk({tag, " level_b"}, int'(level_b), lvl);
    chk({tag, " press_a"}, int'(press_a), prs);
    chk({tag, " press_b"}, int'(press_b), prs);
    chk({tag, " release_a"}, int'(rel_a), rel);
    chk({tag, " release_b"}, int'(rel_b), rel);
    chk({tag, " long_a"}, int'(long_a), lng);
    chk({tag, " long_b"}, int'(long_b), lng);
    chk({tag, " count_a"}, int'(count_a), cnt);
    chk({tag, " count_b"}, int'(count_b), cnt);
    $display("step %s: level=%0d/%0d press=%0d/%0d release=%0d/%0d long=%0d/%0d count=%0d/%0d",
             tag, level_a, level_b, press_a, press_b, rel_a, rel_b, long_a, long_b,
             count_a, count_b);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    chk_out("in_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(1);
    chk_out("after_reset", 0, 0, 0, 0, 0);

    // Clean press: strobe after edge 6, long press after edge 16
    pin_a = 1'b0;
    step(5);
    chk_out("press_edge5", 0, 0, 0, 0, 0);
    step(1);
    chk_out("press_edge6", 1, 1, 0, 0, 1);
    step(1);
    chk_out("press_edge7", 1, 0, 0, 0, 1);
    step(8);
    chk_out("long_edge15", 1, 0, 0, 0, 1);
    step(1);
    chk_out("long_edge16", 1, 0, 0, 1, 1);
    step(1);
    chk_out("long_edge17", 1, 0, 0, 0, 1);
    step(20);
    chk("long_once_a", long_n_a, 1);
    chk("long_once_b", long_n_b, 1);

    // Clean release
    pin_a = 1'b1;
    step(5);
    chk_out("release_edge5", 1, 0, 0, 0, 1);
    step(1);
    chk_out("release_edge6", 0, 0, 1, 0, 1);
    step(1);
    chk_out("release_edge7", 0, 0, 0, 0, 1);
    step(3);

    // Glitch of three samples is rejected
    pin_a = 1'b0;
    step(3);
    pin_a = 1'b1;
    step(10);
    chk_out("glitch", 0, 0, 0, 0, 1);
    chk("glitch_press_n_a", press_n_a, 1);
    chk("glitch_press_n_b", press_n_b, 1);

    // Press, then a two-sample release bounce that must not release
    pin_a = 1'b0;
    step(6);
    chk_out("press2", 1, 1, 0, 0, 2);
    step(2);
    pin_a = 1'b1;
    step(2);
    pin_a = 1'b0;
    step(10);
    chk_out("bounce", 1, 0, 0, 0, 2);
    chk("bounce_rel_n_a", rel_n_a, 1);
    chk("bounce_rel_n_b", rel_n_b, 1);
    chk("bounce_long_n_a", long_n_a, 2);
    chk("bounce_long_n_b", long_n_b, 2);
    pin_a = 1'b1;
    step(5);
    chk_out("release2_edge5", 1, 0, 0, 0, 2);
    step(1);
    chk_out("release2_edge6", 0, 0, 1, 0, 2);
    step(4);

    // 256 clean cycles from a fresh reset: count walks 1..255 then wraps to 0
    do_reset();
    chk_out("wrap_start", 0, 0, 0, 0, 0);
    base_press = press_n_a;
    base_rel   = rel_n_a;
    for (int i = 0; i < 256; i++) begin
      pin_a = 1'b0;
      step(7);
      chk("wrap_count_a", int'(count_a), (i + 1) % 256);
      chk("wrap_count_b", int'(count_b), (i + 1) % 256);
      pin_a = 1'b1;
      step(7);
    end
    $display("wrap: count=%0d/%0d presses=%0d releases=%0d", count_a, count_b,
             press_n_a - base_press, rel_n_a - base_rel);
    chk("wrap_final_count_a", int'(count_a), 0);
    chk("wrap_press_pulses", press_n_a - base_press, 256);
    chk("wrap_release_pulses", rel_n_a - base_rel, 256);
    chk("wrap_press_pulses_b", press_n_b, press_n_a);
    chk("wrap_release_pulses_b", rel_n_b, rel_n_a);

    // One more press so the counter is nonzero, then reset in CONFIRM_PRESS with cnt = 2
    pin_a = 1'b0;
    step(7);
    chk_out("pre_reset_press", 1, 0, 0, 0, 1);
    pin_a = 1'b1;
    step(10);
    pin_a = 1'b0;
    step(4);
    reset = 1'b1;
    #2;
    chk_out("async_reset", 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    step(5);
    chk_out("post_reset_edge5", 0, 0, 0, 0, 0);
    step(1);
    chk_out("post_reset_edge6", 1, 1, 0, 0, 1);
    step(1);
    chk_out("post_reset_edge7", 1, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
